nios2_ocimem_arbiter: RTL
=========================

// Module: nios2_ocimem_arbiter
// PURPOSE
//  Sysclk-domain controller for the Nios II on-chip debug monitor RAM. Shares one single-port RAM
//  between JTAG debug commands (take_action_* pulses + jdo from the debug slave sysclk stage) and
//  the CPU debug Avalon-MM slave. Sequences accesses and returns JTAG read data in MonDReg.
// PARAMETERS
//  AW             8   RAM word-address width; depth 2**AW x 32 bits
//  JTAG_PRIORITY  0   1: pending JTAG always wins; 0: round-robin when both requesters pend
// PORTS
//  clk                      in   1   system clock
//  reset_n                  in   1   asynchronous active-low reset
//  jdo                      in   38  JTAG data; addr = jdo[AW+1:2], wdata = jdo[31:0]
//  take_action_ocimem_a     in   1   pulse: load JTAG address from jdo
//  take_action_ocimem_b     in   1   pulse: JTAG write jdo[31:0] at address, then address+1
//  take_no_action_ocimem_a  in   1   pulse: JTAG read at address into MonDReg, then address+1
//  avs_address              in   AW  CPU word address
//  avs_read / avs_write     in   1   CPU read / write strobes, held until waitrequest low
//  avs_writedata            in   32  CPU write data
//  avs_byteenable           in   4   CPU byte enables (JTAG writes always use 4'hF)
//  avs_waitrequest          out  1   stall CPU; low exactly in the completing cycle
//  avs_readdata             out  32  CPU read data, valid while waitrequest low on a read
//  ram_addr                 out  AW  RAM address
//  ram_we                   out  1   RAM write enable
//  ram_be                   out  4   RAM byte enables
//  ram_wdata                out  32  RAM write data
//  ram_rdata                in   32  RAM read data, 1-cycle latency after ram_addr
//  MonDReg                  out  32  last JTAG read result
//  monitor_ready            out  1   high when no JTAG command pending or in flight
//  monitor_error            out  1   sticky JTAG overrun flag
// BEHAVIOUR
//  - Reset (async): state IDLE, MonDReg=0, jtag_addr=0, pending cleared, monitor_ready=1,
//    monitor_error=0, avs_waitrequest=1, ram_we=0, ram_addr=0, ram_be=0, ram_wdata=0, avs_readdata=0.
//    Reset mid-access aborts it; no partial RAM write after deassertion.
//  - JTAG pulses register a single-entry pending cmd (RD/WR); monitor_ready drops next cycle.
//  - ocimem_a with ocimem_b or read pulse in same cycle: address loads first, cmd uses new address.
//  - Write and read pulse same cycle: write kept, read dropped, monitor_error set.
//  - New cmd while one pending/in flight: dropped, monitor_error set.
//  - monitor_error clears only on take_action_ocimem_a.
//  - FSM: IDLE, J_ACC, J_RD, C_ACC, C_RD.
//    IDLE: pick requester; JTAG pending or CPU strobe -> J_ACC / C_ACC. If both, JTAG_PRIORITY=1 -> JTAG,
//    else grant the side not granted last; last_grant updates on each grant.
//    J_ACC: drive ram_addr=jtag_addr. WR: ram_we=1, be=F, jtag_addr+1, clear pending -> IDLE.
//    RD: -> J_RD.
//    J_RD: MonDReg<=ram_rdata, jtag_addr+1, clear pending -> IDLE.
//    C_ACC: drive ram_addr=avs_address. Write: ram_we=1, be=avs_byteenable, waitrequest=0 -> IDLE.
//    Read: -> C_RD.
//    C_RD: avs_readdata=ram_rdata, waitrequest=0 -> IDLE.
//  - Latency from IDLE: CPU write 2 cycles (1 wait); CPU read 3 cycles (2 wait); JTAG write,
//    monitor_ready back 3 cycles after pulse; JTAG read 4.
//  - jtag_addr wraps 2**AW-1 -> 0. avs_read and avs_write together: write wins.
//  - ram_we only in J_ACC/C_ACC write cycles. MonDReg changes only in J_RD.
// TESTING
//  - Reset, idle: all outputs at reset values, monitor_ready=1, waitrequest=1.
//  - CPU write 0x12345678 @5, be=F; then read @5 -> readdata 0x12345678, waitrequest low
//    on 2nd/3rd cycle.
//  - JTAG a(addr=0xFF) + b(0xCAFEF00D), then read pulse -> RAM[0xFF] written, MonDReg=RAM[0x00]
//    (wrap), monitor_ready restored.
//  - CPU read held + JTAG read pending same cycle, JTAG_PRIORITY=0 -> alternating grants, neither
//    starves over 8 requests; JTAG_PRIORITY=1 -> JTAG first.
//  - Second JTAG pulse while monitor_ready=0 -> monitor_error=1, dropped, RAM unchanged; next
//    ocimem_a clears it.
//  - reset_n low during C_ACC write cycle -> no write, waitrequest=1, state IDLE on release.

Source files
------------

// File: rtl/nios2_ocimem_arbiter.sv
// Debug monitor RAM sequencer: shares one single-port RAM between JTAG commands and the CPU debug slave.
// CPU write 1 wait / read 2 waits, JTAG ready 3 (wr) / 4 (rd) cycles after pulse; CPU stalls on waitrequest, JTAG overruns drop.
module nios2_ocimem_arbiter #(
  parameter int AW            = 8,
  parameter int JTAG_PRIORITY = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic          take_no_action_ocimem_a,
  input  logic [AW-1:0] avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  input  logic [3:0]    avs_byteenable,
  output logic          avs_waitrequest,
  output logic [31:0]   avs_readdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [3:0]    ram_be,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  typedef enum logic [2:0] {IDLE, J_ACC, J_RD, C_ACC, C_RD} state_t;

  state_t        state, state_nxt;
  logic          pend_vld;
  logic          pend_wr;
  logic [31:0]   pend_dat;
  logic [AW-1:0] jtag_addr;
  logic          last_cpu;
  logic          jtag_done;
  logic          mon_ld;
  logic          cmd_in;
  logic          cmd_err;
  logic          cpu_req;
  logic          jtag_win;
  logic          unused_jdo;

  assign unused_jdo = ^jdo[37:32];

  assign cmd_in  = take_action_ocimem_b | take_no_action_ocimem_a;
  // Overrun: any command while one is outstanding, or write+read in the same cycle.
  assign cmd_err = (cmd_in & pend_vld) | (take_action_ocimem_b & take_no_action_ocimem_a);
  assign cpu_req = avs_read | avs_write;
  // On a tie, JTAG wins under fixed priority or when the CPU held the last grant.
  assign jtag_win = pend_vld & (~cpu_req | (JTAG_PRIORITY != 0) | last_cpu);

  assign monitor_ready = ~pend_vld;

  always_comb begin
    state_nxt       = state;
    avs_waitrequest = 1'b1;
    avs_readdata    = 32'h0;
    ram_addr        = '0;
    ram_we          = 1'b0;
    ram_be          = 4'h0;
    ram_wdata       = 32'h0;
    jtag_done       = 1'b0;
    mon_ld          = 1'b0;
    case (state)
      IDLE: begin
        if (jtag_win) begin
          state_nxt = J_ACC;
        end else if (cpu_req) begin
          state_nxt = C_ACC;
        end
      end
      J_ACC: begin
        ram_addr = jtag_addr;
        if (pend_wr) begin
          ram_we    = 1'b1;
          ram_be    = 4'hF;
          ram_wdata = pend_dat;
          jtag_done = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = J_RD;
        end
      end
      J_RD: begin
        mon_ld    = 1'b1;
        jtag_done = 1'b1;
        state_nxt = IDLE;
      end
      C_ACC: begin
        ram_addr = avs_address;
        if (avs_write) begin
          ram_we          = 1'b1;
          ram_be          = avs_byteenable;
          ram_wdata       = avs_writedata;
          avs_waitrequest = 1'b0;
          state_nxt       = IDLE;
        end else begin
          state_nxt = C_RD;
        end
      end
      C_RD: begin
        avs_readdata    = ram_rdata;
        avs_waitrequest = 1'b0;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Reset value makes JTAG the first winner of a tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_cpu <= 1'b1;
    end else if (state == IDLE && state_nxt == J_ACC) begin
      last_cpu <= 1'b0;
    end else if (state == IDLE && state_nxt == C_ACC) begin
      last_cpu <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld <= 1'b0;
      pend_wr  <= 1'b0;
      pend_dat <= 32'h0;
    end else if (cmd_in && !pend_vld) begin
      pend_vld <= 1'b1;
      pend_wr  <= take_action_ocimem_b;
      pend_dat <= jdo[31:0];
    end else if (jtag_done) begin
      pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      monitor_error <= 1'b0;
    end else if (cmd_err) begin
      monitor_error <= 1'b1;
    end else if (take_action_ocimem_a) begin
      monitor_error <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jtag_addr <= '0;
    end else if (take_action_ocimem_a) begin
      jtag_addr <= jdo[AW+1:2];
    end else if (jtag_done) begin
      jtag_addr <= jtag_addr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MonDReg <= 32'h0;
    end else if (mon_ld) begin
      MonDReg <= ram_rdata;
    end
  end

endmodule
